// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

  localparam int unsigned DepthDefault = 24;

  // funct3 size/sign encodings
  localparam logic [2:0] Funct3B  = 3'd0;
  localparam logic [2:0] Funct3H  = 3'd1;
  localparam logic [2:0] Funct3W  = 3'd2;
  localparam logic [2:0] Funct3Bu = 3'd4;
  localparam logic [2:0] Funct3Hu = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory and writeback signals of the load/store unit.
interface load_store_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic [31:0] address;
  logic [31:0] write_data_mem;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;
  logic        wb_valid;
  logic        wb_we;
  logic        wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Environment side: execute stage, data memory and writeback consumer
  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3, ex_addr, ex_wdata,
           ex_rd, read_data,
    input  ex_ready, address, write_data_mem, mem_read, mem_write, wb_valid, wb_we, wb_fault,
           wb_rd, wb_data
  );

  // Load/store unit side
  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3, ex_addr, ex_wdata,
           ex_rd, read_data,
    output ex_ready, address, write_data_mem, mem_read, mem_write, wb_valid, wb_we, wb_fault,
           wb_rd, wb_data
  );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [31:0] lane_mask;

  // Move the addressed lane to bit 0, then sign- or zero-extend
  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      Funct3B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      Funct3H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      Funct3Bu: load_data = {24'h0, shifted[7:0]};
      Funct3Hu: load_data = {16'h0, shifted[15:0]};
      default:  load_data = shifted;
    endcase
  end

  // Replace only the addressed lanes of the old word with the low store bytes
  always_comb begin
    case (funct3)
      Funct3B: lane_mask = 32'h0000_00ff;
      Funct3H: lane_mask = 32'h0000_ffff;
      default: lane_mask = 32'hffff_ffff;
    endcase
    lane_mask = lane_mask << {byte_off, 3'b000};
    merged    = (rdata & ~lane_mask) | ((wdata << {byte_off, 3'b000}) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDefault
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_e  state_q, state_d;
  logic        ex_ready_q, ex_ready_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_mem_q, write_data_mem_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_fault_q, wb_fault_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [2:0]  req_funct3_q, req_funct3_d;
  logic [1:0]  req_off_q, req_off_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic        req_reg_write_q, req_reg_write_d;

  logic        is_mem, f3_legal, misaligned, out_of_range, fault;
  logic [31:0] load_data, merged;

  load_store_align u_align (
    .funct3    (req_funct3_q),
    .byte_off  (req_off_q),
    .rdata     (bus.read_data),
    .wdata     (req_wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Classify the incoming request and detect access faults
  always_comb begin
    is_mem = bus.ex_mem_read || bus.ex_mem_write;
    if (bus.ex_mem_write) begin
      f3_legal = bus.ex_funct3 inside {Funct3B, Funct3H, Funct3W};
    end else begin
      f3_legal = bus.ex_funct3 inside {Funct3B, Funct3H, Funct3W, Funct3Bu, Funct3Hu};
    end
    misaligned   = ((bus.ex_funct3 == Funct3H || bus.ex_funct3 == Funct3Hu) && bus.ex_addr[0])
                || (bus.ex_funct3 == Funct3W && bus.ex_addr[1:0] != 2'b00);
    out_of_range = {2'b00, bus.ex_addr[31:2]} >= DEPTH;
    fault        = is_mem && ((bus.ex_mem_read && bus.ex_mem_write) || !f3_legal || misaligned
                           || out_of_range);
  end

  // Next state and next registered outputs
  always_comb begin
    state_d          = state_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    address_d        = address_q;
    write_data_mem_d = write_data_mem_q;
    wb_valid_d       = 1'b0;
    wb_we_d          = 1'b0;
    wb_fault_d       = 1'b0;
    wb_rd_d          = 5'd0;
    wb_data_d        = 32'd0;
    req_funct3_d     = req_funct3_q;
    req_off_d        = req_off_q;
    req_wdata_d      = req_wdata_q;
    req_rd_d         = req_rd_q;
    req_reg_write_d  = req_reg_write_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ex_valid) begin
          req_funct3_d    = bus.ex_funct3;
          req_off_d       = bus.ex_addr[1:0];
          req_wdata_d     = bus.ex_wdata;
          req_rd_d        = bus.ex_rd;
          req_reg_write_d = bus.ex_reg_write;
          if (fault || !is_mem) begin
            // No memory access: answer straight away
            state_d    = StResp;
            wb_valid_d = 1'b1;
            wb_fault_d = fault;
            wb_we_d    = bus.ex_reg_write && !fault;
            wb_rd_d    = bus.ex_rd;
            wb_data_d  = fault ? 32'd0 : bus.ex_addr;
          end else begin
            address_d = {2'b00, bus.ex_addr[31:2]};
            if (bus.ex_mem_read) begin
              state_d    = StLoad;
              mem_read_d = 1'b1;
            end else if (bus.ex_funct3 == Funct3W) begin
              state_d          = StStore;
              mem_write_d      = 1'b1;
              write_data_mem_d = bus.ex_wdata;
            end else begin
              state_d    = StRmwRd;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      StLoad: begin
        state_d    = StResp;
        wb_valid_d = 1'b1;
        wb_we_d    = req_reg_write_q;
        wb_rd_d    = req_rd_q;
        wb_data_d  = load_data;
      end
      StRmwRd: begin
        state_d          = StRmwWr;
        mem_write_d      = 1'b1;
        write_data_mem_d = merged;
      end
      StStore, StRmwWr: begin
        state_d    = StResp;
        wb_valid_d = 1'b1;
        wb_rd_d    = req_rd_q;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    ex_ready_d = (state_d == StIdle);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      ex_ready_q       <= 1'b1;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      address_q        <= 32'd0;
      write_data_mem_q <= 32'd0;
      wb_valid_q       <= 1'b0;
      wb_we_q          <= 1'b0;
      wb_fault_q       <= 1'b0;
      wb_rd_q          <= 5'd0;
      wb_data_q        <= 32'd0;
      req_funct3_q     <= 3'd0;
      req_off_q        <= 2'd0;
      req_wdata_q      <= 32'd0;
      req_rd_q         <= 5'd0;
      req_reg_write_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      ex_ready_q       <= ex_ready_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      address_q        <= address_d;
      write_data_mem_q <= write_data_mem_d;
      wb_valid_q       <= wb_valid_d;
      wb_we_q          <= wb_we_d;
      wb_fault_q       <= wb_fault_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      req_funct3_q     <= req_funct3_d;
      req_off_q        <= req_off_d;
      req_wdata_q      <= req_wdata_d;
      req_rd_q         <= req_rd_d;
      req_reg_write_q  <= req_reg_write_d;
    end
  end

  assign bus.ex_ready       = ex_ready_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.address        = address_q;
  assign bus.write_data_mem = write_data_mem_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_we          = wb_we_q;
  assign bus.wb_fault       = wb_fault_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: request-level model checked every cycle plus directed literals.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned Depth = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.DEPTH(Depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [Depth];
  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int accepts = 0;
  logic checking = 1'b0;
  logic [31:0] got_data[$];
  logic got_we[$];
  logic got_fault[$];

  // Data memory: combinational read, write on the clock edge
  always_comb bus.read_data = (bus.address < Depth) ? mem[bus.address[4:0]] : 32'h0;
  always @(posedge clk) begin
    if (bus.mem_write && bus.address < Depth) mem[bus.address[4:0]] <= bus.write_data_mem;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the request in flight
  bit busy = 0;
  bit done = 0;
  int cyc, lat, rd_at, wr_at;
  logic [31:0] e_addr, e_wdata, e_data;
  logic e_we, e_fault, e_data_chk;
  logic [4:0] e_rd;

  task automatic predict();
    int unsigned a, idx, size, sh;
    logic [2:0] f3;
    logic ld, st, bad;
    logic [31:0] word, mask, v;
    a = bus.ex_addr;
    f3 = bus.ex_funct3;
    ld = bus.ex_mem_read;
    st = bus.ex_mem_write;
    idx = a / 4;
    size = 1 << (f3 % 4);
    rd_at = 0;
    wr_at = 0;
    e_addr = idx;
    e_rd = bus.ex_rd;
    e_data_chk = 1;
    e_fault = 0;
    if (!ld && !st) begin
      lat = 1; e_data = a; e_we = bus.ex_reg_write;
    end else begin
      bad = (ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
         || (st && f3 > 3'd2) || (a % size != 0) || (idx >= Depth);
      if (bad) begin
        lat = 1; e_fault = 1; e_data = 0; e_we = 0;
      end else if (ld) begin
        lat = 2; rd_at = 1;
        word = mem[idx];
        sh = 8 * (a % 4);
        mask = (size == 4) ? 32'hffff_ffff : ((32'h1 << (8 * size)) - 1);
        v = (word >> sh) & mask;
        if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
        e_data = v; e_we = bus.ex_reg_write;
      end else if (size == 4) begin
        lat = 2; wr_at = 1; e_wdata = bus.ex_wdata; e_we = 0; e_data_chk = 0;
      end else begin
        lat = 3; rd_at = 1; wr_at = 2;
        word = mem[idx];
        for (int i = 0; i < int'(size); i++) word[8 * ((a % 4) + i) +: 8] = bus.ex_wdata[8 * i +: 8];
        e_wdata = word; e_we = 0; e_data_chk = 0;
      end
    end
  endtask

  // Model update on the rising edge, output comparison on the falling edge
  initial begin : model
    logic exr, exw, exv;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        busy = 0; done = 0;
      end else if (busy && done) begin
        busy = 0; done = 0;
      end else if (!busy && bus.ex_valid) begin
        predict();
        busy = 1; cyc = 0; accepts++;
      end
      @(negedge clk);
      if (checking) begin
        if (busy && !done) cyc++;
        exr = busy && !done && cyc == rd_at;
        exw = busy && !done && cyc == wr_at;
        exv = busy && !done && cyc == lat;
        check("ex_ready", 32'(bus.ex_ready), 32'(!busy));
        check("mem_read", 32'(bus.mem_read), 32'(exr));
        check("mem_write", 32'(bus.mem_write), 32'(exw));
        check("wb_valid", 32'(bus.wb_valid), 32'(exv));
        check("strobe_exclusive", 32'(bus.mem_read && bus.mem_write), 32'd0);
        if (exr || exw) check("address", bus.address, e_addr);
        if (exw) check("write_data_mem", bus.write_data_mem, e_wdata);
        if (bus.mem_read) rd_cycles++;
        if (bus.mem_write) wr_cycles++;
        if (bus.wb_valid) begin
          got_data.push_back(bus.wb_data);
          got_we.push_back(bus.wb_we);
          got_fault.push_back(bus.wb_fault);
        end
        if (exv) begin
          check("wb_we", 32'(bus.wb_we), 32'(e_we));
          check("wb_fault", 32'(bus.wb_fault), 32'(e_fault));
          check("wb_rd", 32'(bus.wb_rd), 32'(e_rd));
          if (e_data_chk) check("wb_data", bus.wb_data, e_data);
          done = 1;
        end
      end
    end
  end

  // Present a request at a falling edge and hold it until accepted
  task automatic issue(input logic r, input logic w, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdst);
    int n0;
    n0 = accepts;
    bus.ex_valid = 1'b1;
    bus.ex_mem_read = r;
    bus.ex_mem_write = w;
    bus.ex_reg_write = rw;
    bus.ex_funct3 = f3;
    bus.ex_addr = a;
    bus.ex_wdata = wd;
    bus.ex_rd = rdst;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (accepts != n0) break;
    end
    if (accepts == n0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept, expected accept of addr %h", a);
    end
  endtask

  // Drop valid and scramble the request fields
  task automatic release_req();
    bus.ex_valid = 1'b0;
    bus.ex_mem_read = 1'($urandom);
    bus.ex_mem_write = 1'($urandom);
    bus.ex_reg_write = 1'($urandom);
    bus.ex_funct3 = 3'($urandom);
    bus.ex_addr = $urandom;
    bus.ex_wdata = $urandom;
    bus.ex_rd = 5'($urandom);
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (got_data.size() >= n) break;
    end
    if (got_data.size() < n) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got %0d responses, expected %0d", got_data.size(), n);
    end
    @(negedge clk);
  endtask

  task automatic single(input string name, input logic r, input logic w, input logic rw,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit chk_data, input logic [31:0] x_data, input logic x_we,
                        input logic x_fault, input int x_rd, input int x_wr);
    int r0, w0, n;
    r0 = rd_cycles; w0 = wr_cycles; n = got_data.size();
    issue(r, w, rw, f3, a, wd, 5'd7);
    release_req();
    wait_resp(n + 1);
    if (got_data.size() > n) begin
      if (chk_data) check({name, "_data"}, got_data[n], x_data);
      check({name, "_we"}, 32'(got_we[n]), 32'(x_we));
      check({name, "_fault"}, 32'(got_fault[n]), 32'(x_fault));
    end
    check({name, "_rd_cycles"}, rd_cycles - r0, x_rd);
    check({name, "_wr_cycles"}, wr_cycles - w0, x_wr);
  endtask

  initial begin : stimulus
    int r0, w0, n;
    for (int i = 0; i < int'(Depth); i++) mem[i] = 32'h0101_0101 * i;
    mem[1] = 32'h8001_1234;
    mem[3] = 32'h1122_3344;
    mem[23] = 32'hcafe_f00d;
    release_req();
    @(posedge clk);
    @(posedge clk);
    checking = 1'b1;
    @(negedge clk);
    check("reset_ex_ready", 32'(bus.ex_ready), 32'd1);
    check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset_wb_data", bus.wb_data, 32'd0);
    check("reset_address", bus.address, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single("lh_6", 1, 0, 1, Funct3H, 32'h6, 32'h0, 1, 32'hffff_8001, 1, 0, 1, 0);
    single("lhu_6", 1, 0, 1, Funct3Hu, 32'h6, 32'h0, 1, 32'h0000_8001, 1, 0, 1, 0);
    single("lb_7", 1, 0, 1, Funct3B, 32'h7, 32'h0, 1, 32'hffff_ff80, 1, 0, 1, 0);
    single("lbu_4", 1, 0, 0, Funct3Bu, 32'h4, 32'h0, 1, 32'h0000_0034, 0, 0, 1, 0);
    single("sb_d", 0, 1, 1, Funct3B, 32'hd, 32'hab, 0, 32'h0, 0, 0, 1, 1);
    check("sb_d_mem", mem[3], 32'h1122_ab44);
    single("sw_c", 0, 1, 0, Funct3W, 32'hc, 32'h1122_3344, 0, 32'h0, 0, 0, 0, 1);
    check("sw_c_mem", mem[3], 32'h1122_3344);

    // Back-to-back: valid stays high across both requests
    r0 = rd_cycles; n = got_data.size();
    issue(1, 0, 1, Funct3Bu, 32'hc, 32'h0, 5'd3);
    issue(1, 0, 1, Funct3W, 32'hc, 32'h0, 5'd4);
    release_req();
    wait_resp(n + 2);
    if (got_data.size() >= n + 2) begin
      check("b2b_lbu_data", got_data[n], 32'h0000_0044);
      check("b2b_lw_data", got_data[n + 1], 32'h1122_3344);
    end
    check("b2b_rd_cycles", rd_cycles - r0, 2);

    single("lw_misaligned", 1, 0, 1, Funct3W, 32'h2, 32'h0, 1, 32'h0, 0, 1, 0, 0);
    single("sw_range", 0, 1, 0, Funct3W, 32'h60, 32'h1234, 1, 32'h0, 0, 1, 0, 0);
    single("lw_last", 1, 0, 1, Funct3W, 32'h5c, 32'h0, 1, 32'hcafe_f00d, 1, 0, 1, 0);
    single("alu_op", 0, 0, 1, 3'd7, 32'hdead_beef, 32'h0, 1, 32'hdead_beef, 1, 0, 0, 0);
    single("rd_and_wr", 1, 1, 1, Funct3W, 32'h4, 32'h0, 1, 32'h0, 0, 1, 0, 0);
    single("load_f3_3", 1, 0, 1, 3'd3, 32'h8, 32'h0, 1, 32'h0, 0, 1, 0, 0);
    single("sh_misaligned", 0, 1, 0, Funct3H, 32'h5, 32'h0, 1, 32'h0, 0, 1, 0, 0);
    single("store_f3_bu", 0, 1, 0, Funct3Bu, 32'h4, 32'h0, 1, 32'h0, 0, 1, 0, 0);
    single("sh_6", 0, 1, 1, Funct3H, 32'h6, 32'hffff_5566, 0, 32'h0, 0, 0, 1, 1);
    check("sh_6_mem", mem[1], 32'h5566_1234);

    // Reset while the read half of a read-modify-write is on the bus
    w0 = wr_cycles; n = got_data.size();
    issue(0, 1, 0, Funct3H, 32'h4, 32'h7777, 5'd1);
    check("rmw_rd_mem_read", 32'(bus.mem_read), 32'd1);
    release_req();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_resp", got_data.size(), n);
    check("rst_no_write", wr_cycles - w0, 0);
    check("rst_mem_kept", mem[1], 32'h5566_1234);
    check("rst_ex_ready", 32'(bus.ex_ready), 32'd1);

    single("lw_after_rst", 1, 0, 1, Funct3W, 32'h4, 32'h0, 1, 32'h5566_1234, 1, 0, 1, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 24, data memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port ex_valid  input  1  request from execute stage.
REQ-005 SHALL have port ex_ready  output  1  unit can accept a request.
REQ-006 SHALL have ports ex_mem_read, ex_mem_write, ex_reg_write  input  1 each  operation class and writeback enable.
REQ-007 SHALL have port ex_funct3  input  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-008 SHALL have ports ex_addr, ex_wdata  input  32 each  byte address (ALU result) and store data.
REQ-009 SHALL have port ex_rd  input  5  destination register.
REQ-010 SHALL have ports address, write_data_mem  output  32 each  word index (byte address >> 2) and write word to data memory.
REQ-011 SHALL have ports mem_read, mem_write  output  1 each  data memory strobes.
REQ-012 SHALL have port read_data  input  32  data memory read word.
REQ-013 SHALL have ports wb_valid, wb_we, wb_fault  output  1 each  writeback result valid, register-write enable, access fault.
REQ-014 SHALL have ports wb_rd  output  5  and wb_data  output  32  writeback destination and value.

Function
REQ-015 SHALL use states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP; ex_ready=1 only in IDLE.
REQ-016 SHALL accept on ex_valid&&ex_ready and latch all ex_* inputs.
REQ-017 SHALL flag fault if: both mem_read and mem_write set, illegal funct3 for the class, H not 2-byte aligned, W not 4-byte aligned, or word index >= DEPTH.
REQ-018 Faulted or non-memory request: IDLE->RESP, no memory strobe; non-memory wb_data=ex_addr.
REQ-019 Load: IDLE->LOAD (mem_read=1) ->RESP; read_data sampled at edge leaving LOAD; wb_valid asserted 2 cycles after accept.
REQ-020 SW: IDLE->STORE (mem_write=1, write_data_mem=ex_wdata) ->RESP.
REQ-021 SB/SH: IDLE->RMW_RD (mem_read=1, capture word) ->RMW_WR (mem_write=1, merged word, only addressed lanes replaced) ->RESP.
REQ-022 Load extract: lane by ex_addr[1:0]; B/H sign-extend, BU/HU zero-extend.
REQ-023 RESP: wb_valid=1 for exactly one cycle, then IDLE; wb_we=ex_reg_write&&!fault&&!store; wb_fault=fault.
REQ-024 mem_read and mem_write SHALL never be 1 in the same cycle; address stable while either is high.
REQ-025 All outputs SHALL be registered; wb_data=0 when wb_fault=1.
REQ-026 ex_valid dropping after acceptance SHALL not affect the in-flight operation.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, all outputs 0 except ex_ready=1 after release.
REQ-028 Reset mid-operation SHALL abandon it: no mem_write and no wb_valid for that request afterward.

Structure
REQ-029 Package lsu_pkg SHALL hold funct3 constants, state enum, DEPTH default.
REQ-030 One combinational sub-module load_store_align SHALL perform lane extract/extend and store merge.

Verification
REQ-031 Word 1=0x80011234; LH addr 0x6 -> mem_read one cycle, wb_data=0xFFFF8001, wb_we=1.
REQ-032 Word 3=0x11223344; SB addr 0xD wdata 0xAB -> read then write 0x1122AB44, wb_we=0.
REQ-033 LW addr 0x2 -> wb_fault=1, wb_data=0, mem_read never asserted.
REQ-034 SW addr 0x60 (DEPTH 24) -> fault, mem_write never asserted.
REQ-035 rst_n=0 during RMW_RD -> no mem_write, no wb_valid, IDLE with ex_ready=1 after release.
REQ-036 Back-to-back LBU 0xC, LW 0xC -> 0x44 then 0x11223344; ex_ready low between them.
